// File: rtl/decode_12.sv
// ============================================================================
// decode_12 : ByteDecode12 unpacker, 3 bytes in -> two 12-bit coefficients out
// Revision  : 1.0
// ============================================================================
`default_nettype none

module decode_12 (
  input  logic        clk,
  input  logic        reset,
  input  logic        set,
  input  logic        readin,
  input  logic [7:0]  din,
  input  logic [15:0] in_index,
  output logic [15:0] dout_1,
  output logic [15:0] dout_2,
  output logic [15:0] out_index
);

  typedef enum logic [1:0] {
    PH_B0 = 2'd0,
    PH_B1 = 2'd1,
    PH_B2 = 2'd2
  } phase_t;

  phase_t      phase_q, phase_d;
  logic [7:0]  b0_q, b0_d;
  logic [7:0]  b1_q, b1_d;
  logic [15:0] pair_q, pair_d;
  logic [15:0] dout1_q, dout1_d;
  logic [15:0] dout2_q, dout2_d;
  logic [15:0] oidx_q, oidx_d;

  logic        w_accept;
  logic        w_resync;
  phase_t      w_phase;
  logic [15:0] w_pair;

  assign w_accept = set && readin;
  // A byte tagged as stream index 0 always restarts the pair and the pair count.
  assign w_resync = (in_index == 16'd0);
  assign w_phase  = w_resync ? PH_B0 : phase_q;
  assign w_pair   = w_resync ? 16'd0 : pair_q;

  always_comb begin
    phase_d = phase_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    pair_d  = pair_q;
    dout1_d = dout1_q;
    dout2_d = dout2_q;
    oidx_d  = oidx_q;
    if (w_accept) begin
      pair_d = w_pair;
      case (w_phase)
        PH_B0: begin
          b0_d    = din;
          phase_d = PH_B1;
        end
        PH_B1: begin
          b1_d    = din;
          phase_d = PH_B2;
        end
        PH_B2: begin
          dout1_d = {4'h0, b1_q[3:0], b0_q};
          dout2_d = {4'h0, din, b1_q[7:4]};
          oidx_d  = w_pair;
          pair_d  = w_pair + 16'd1;
          phase_d = PH_B0;
        end
        default: begin
          b0_d    = din;
          phase_d = PH_B1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= PH_B0;
      b0_q    <= 8'd0;
      b1_q    <= 8'd0;
      pair_q  <= 16'd0;
      dout1_q <= 16'd0;
      dout2_q <= 16'd0;
      oidx_q  <= 16'd0;
    end else begin
      phase_q <= phase_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      pair_q  <= pair_d;
      dout1_q <= dout1_d;
      dout2_q <= dout2_d;
      oidx_q  <= oidx_d;
    end
  end

  assign dout_1    = dout1_q;
  assign dout_2    = dout2_q;
  assign out_index = oidx_q;

endmodule

`default_nettype wire

// File: tb/tb_decode_12.sv
// ============================================================================
// tb_decode_12 : directed self-checking bench for decode_12
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_decode_12;

  logic        clk;
  logic        reset;
  logic        set;
  logic        readin;
  logic [7:0]  din;
  logic [15:0] in_index;
  logic [15:0] dout_1;
  logic [15:0] dout_2;
  logic [15:0] out_index;

  int n_checks;
  int n_fail;

  decode_12 dut (
    .clk       (clk),
    .reset     (reset),
    .set       (set),
    .readin    (readin),
    .din       (din),
    .in_index  (in_index),
    .dout_1    (dout_1),
    .dout_2    (dout_2),
    .out_index (out_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [15:0] e1, input logic [15:0] e2,
                           input logic [15:0] ei);
    check_eq({tag, ".dout_1"}, dout_1, e1);
    check_eq({tag, ".dout_2"}, dout_2, e2);
    check_eq({tag, ".out_index"}, out_index, ei);
  endtask

  // Inputs are driven 1 time unit after a rising edge, so they are stable
  // at the next edge and outputs are sampled away from it.
  task automatic send(input logic [7:0] d, input logic [15:0] idx);
    din      = d;
    in_index = idx;
    set      = 1'b1;
    readin   = 1'b1;
    @(posedge clk);
    #1;
    readin   = 1'b0;
  endtask

  task automatic idle(input int n);
    readin = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [7:0]  a, b, c;
    logic [15:0] e1, e2;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    set      = 1'b0;
    readin   = 1'b0;
    din      = 8'h00;
    in_index = 16'h0000;

    // Reset held, then released with set low: nothing may be accepted.
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 16'h0000, 16'h0000, 16'h0000);
    reset    = 1'b1;
    set      = 1'b0;
    readin   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din      = (i % 2 == 0) ? 8'hA5 : 8'h5A;
      in_index = 16'(i);
      @(posedge clk);
      #1;
    end
    check_out("set_low", 16'h0000, 16'h0000, 16'h0000);
    readin = 1'b0;

    // Basic pair.
    send(8'h01, 16'd0);
    send(8'h23, 16'd1);
    send(8'h45, 16'd2);
    check_out("basic", 16'h0301, 16'h0452, 16'h0000);

    // Extremes with a stall after the first byte.
    send(8'hFF, 16'd3);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check_eq("stall.dout_1", dout_1, 16'h0301);
      check_eq("stall.dout_2", dout_2, 16'h0452);
    end
    send(8'hFF, 16'd4);
    send(8'hFF, 16'd5);
    check_out("extreme", 16'h0FFF, 16'h0FFF, 16'h0001);

    // Resync abandons a partial pair and restarts the pair count.
    send(8'hAA, 16'd0);
    send(8'hBB, 16'd1);
    send(8'h10, 16'd0);
    send(8'h32, 16'd1);
    send(8'h54, 16'd2);
    check_out("resync", 16'h0210, 16'h0543, 16'h0000);

    // Asynchronous reset mid-pair, between clock edges.
    send(8'h77, 16'd3);
    #2;
    reset = 1'b0;
    #1;
    check_out("async_rst", 16'h0000, 16'h0000, 16'h0000);
    reset = 1'b1;
    @(posedge clk);
    #1;
    send(8'h01, 16'd4);
    send(8'h23, 16'd5);
    send(8'h45, 16'd6);
    check_out("post_rst", 16'h0301, 16'h0452, 16'h0000);

    // Full 1152-byte stream, din = low byte of the stream index.
    for (int i = 0; i < 1152; i++) begin
      send(i[7:0], 16'(i));
      if (i % 3 == 2) begin
        a  = 8'((i - 2) & 255);
        b  = 8'((i - 1) & 255);
        c  = 8'(i & 255);
        e1 = 16'(a) | (16'(b & 8'h0F) << 8);
        e2 = 16'(b >> 4) | (16'(c) << 4);
        check_out("stream", e1, e2, 16'(i / 3));
      end
    end
    check_eq("stream_last_idx", out_index, 16'd383);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/decode_12.md
Name: decode_12

Overview:
Kyber ByteDecode12 unpacker for the encapsulation-key / polynomial byte stream.
- Consumes one byte per accepted cycle.
- Every 3 bytes yields two 12-bit coefficients, zero-extended to 16 bits, with a pair index.
- Sits between the byte-serial key input path and the NTT/polynomial storage that consumes coefficient pairs.

Parameters:
None. Widths are fixed: 8-bit input, 16-bit coefficients, 16-bit indices.

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset; clears all state immediately when low
set  input  1  block enable; no byte accepted while low
readin  input  1  byte-valid qualifier; a byte is accepted on a rising clk edge when set=1 and readin=1
din  input  8  input byte, little-endian packed coefficient stream
in_index  input  16  stream byte index of din (0 = first byte of a stream)
dout_1  output  16  even coefficient 2k of the latest completed pair, bits[15:12]=0
dout_2  output  16  odd coefficient 2k+1 of the latest completed pair, bits[15:12]=0
out_index  output  16  pair index k of the latest completed pair

Behaviour:
- Reset (reset=0, asynchronous):
  - dout_1, dout_2 and out_index = 0.
  - Phase counter = 0 and pair counter = 0.
  - Byte registers b0 and b1 = 0.
  - Takes effect mid-pair too: any partially collected pair is discarded.
- Accept condition: reset=1 AND set=1 AND readin=1 at a rising clk edge. Otherwise all state and outputs hold, including when set=0 with readin=1.
- Resync: an accepted byte with in_index==0 is treated as phase 0 and the pair counter is forced to 0, regardless of current phase.
- Phase 0 (accepted byte): store b0 <= din; phase -> 1.
- Phase 1 (accepted byte): store b1 <= din; phase -> 2.
- Phase 2 (accepted byte b2=din):
  - dout_1 <= {4'h0, b1[3:0], b0}
  - dout_2 <= {4'h0, din, b1[7:4]}
  - out_index <= pair counter value
  - pair counter increments (wraps 0xFFFF -> 0)
  - phase -> 0
- Latency: outputs are registered and change at the same edge that accepts the third byte. They are visible the following cycle and held until the next pair completes.
- Stalls (readin=0 between bytes) are allowed at any phase, for any number of cycles, without affecting results.
- No modulus check: values 3329..4095 pass through unchanged.
- A full 1152-byte stream yields 384 pairs, out_index 0..383 (768 coefficients = 3 polynomials of 256).
- Non-zero in_index values are otherwise informational; no gap or order checking is performed.
- Outputs never contain X after reset deassertion.

Test Plan:
- Reset: hold reset=0 for 2 cycles -> dout_1=dout_2=out_index=0x0000; deassert with set=0, readin=1, din toggling -> outputs stay 0.
- Basic pair: bytes 0x01,0x23,0x45 with in_index 0,1,2 on consecutive cycles -> after third edge dout_1=0x0301, dout_2=0x0452, out_index=0.
- Extremes and stall: bytes 0xFF, [readin=0 for 3 cycles], 0xFF, 0xFF (in_index 3,4,5) following the basic pair -> dout_1=0x0FFF, dout_2=0x0FFF, out_index=1. Outputs hold 0x0301/0x0452 during the stall.
- Resync and reset mid-pair:
  - Send 0xAA,0xBB (in_index 0,1), then restart with in_index=0 bytes 0x10,0x32,0x54 -> dout_1=0x0210, dout_2=0x0543, out_index=0.
  - Pulse reset low after one byte of a pair -> outputs 0, next 3 bytes decode as pair 0.
- Full stream: 1152 bytes i=0..1151 with din=i[7:0], readin=1 continuously -> 384 completions, final out_index=383.
  - Each pair k: dout_1 = b(3k) | (b(3k+1)&0xF)<<8 and dout_2 = b(3k+1)>>4 | b(3k+2)<<4.
  - Pair 0 gives 0x0100/0x0020.
